// File: rtl/bsg_cycle_interval_meter_if.sv
// ---------------------------------------------------------------------------
// bsg_cycle_interval_meter_if
//
// Bundles the signals between the interval meter and its environment:
// the shared counter bus, the start/stop events and the result handshake.
//
// Modports:
//   master : the meter itself (drives busy/v/interval/overflow).
//   slave  : the environment (drives ctr/start/stop/yumi).
//
// Signals:
//   ctr_i       [width_p]  free-running counter value
//   start_v_i   [1]        start-of-interval pulse
//   stop_v_i    [1]        end-of-interval pulse
//   busy_o      [1]        measurement running
//   v_o         [1]        result valid
//   interval_o  [width_p]  measured interval (saturated on overflow)
//   overflow_o  [1]        interval reached or exceeded 2^width_p cycles
//   yumi_i      [1]        consumer accepts the result
//
// Optional (BSG_CYCLE_INTERVAL_METER_MAX_TRACK_EN defined):
//   max_o       [width_p]  largest accepted interval
//   max_clr_i   [1]        clears max_o
// ---------------------------------------------------------------------------
interface bsg_cycle_interval_meter_if #(
  parameter int width_p = 16
);

  logic [width_p-1:0] ctr_i;
  logic               start_v_i;
  logic               stop_v_i;
  logic               busy_o;
  logic               v_o;
  logic [width_p-1:0] interval_o;
  logic               overflow_o;
  logic               yumi_i;
`ifdef BSG_CYCLE_INTERVAL_METER_MAX_TRACK_EN
  logic [width_p-1:0] max_o;
  logic               max_clr_i;
`endif

  modport master (
`ifdef BSG_CYCLE_INTERVAL_METER_MAX_TRACK_EN
    output max_o,
    input  max_clr_i,
`endif
    input  ctr_i,
    input  start_v_i,
    input  stop_v_i,
    output busy_o,
    output v_o,
    output interval_o,
    output overflow_o,
    input  yumi_i
  );

  modport slave (
`ifdef BSG_CYCLE_INTERVAL_METER_MAX_TRACK_EN
    input  max_o,
    output max_clr_i,
`endif
    output ctr_i,
    output start_v_i,
    output stop_v_i,
    input  busy_o,
    input  v_o,
    input  interval_o,
    input  overflow_o,
    output yumi_i
  );

endinterface

// File: rtl/bsg_cycle_interval_meter.sv
// ---------------------------------------------------------------------------
// bsg_cycle_interval_meter
//
// Samples a shared free-running counter on start and stop events and
// reports the elapsed cycle count (modulo 2^width_p) through a valid/yumi
// handshake. If the counter returns to the start value while running, the
// interval is at least 2^width_p cycles: the result is flagged as overflowed
// and the interval saturates to all ones.
//
// Ports:
//   clk_i      : clock, rising edge
//   reset_n_i  : asynchronous active-low reset
//   meter_if   : bsg_cycle_interval_meter_if.master (counter, events, result)
//
// Optional feature macro: BSG_CYCLE_INTERVAL_METER_MAX_TRACK_EN
//   When defined, meter_if.max_o tracks the largest accepted interval
//   (all ones after an overflowed result) and meter_if.max_clr_i clears it.
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module bsg_cycle_interval_meter #(
  parameter int width_p = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  bsg_cycle_interval_meter_if.master    meter_if
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q,    state_d;
  logic [width_p-1:0] start_q,    start_d;
  logic               ovf_q,      ovf_d;
  logic [width_p-1:0] interval_q, interval_d;
  logic               overflow_q, overflow_d;
  logic               busy_q,     busy_d;
  logic               v_q,        v_d;

  // Counter is back at the start value: a full 2^width_p cycles elapsed.
  logic               ctr_hit_s;
  logic               ovf_now_s;

  // Wrap detection and next-state / datapath computation.
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    ovf_d      = ovf_q;
    interval_d = interval_q;
    overflow_d = overflow_q;
    ctr_hit_s  = (meter_if.ctr_i == start_q);
    ovf_now_s  = ovf_q | ctr_hit_s;

    case (state_q)
      ST_IDLE: begin
        // A simultaneous stop is dropped: start wins.
        if (meter_if.start_v_i) begin
          start_d = meter_if.ctr_i;
          ovf_d   = 1'b0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ctr_hit_s) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = ovf_q;
        end
        // start_v_i is ignored here, so start_q keeps the original sample.
        if (meter_if.stop_v_i) begin
          overflow_d = ovf_now_s;
          if (ovf_now_s) begin
            interval_d = {width_p{1'b1}};
          end else begin
            // Unsigned subtraction wraps naturally modulo 2^width_p.
            interval_d = meter_if.ctr_i - start_q;
          end
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        // Events are ignored until the result is taken; no restart in the
        // yumi cycle itself.
        if (meter_if.yumi_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered copies of the next state.
    busy_d = (state_d == ST_RUN);
    v_d    = (state_d == ST_DONE);
  end

  // State and result registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      start_q    <= {width_p{1'b0}};
      ovf_q      <= 1'b0;
      interval_q <= {width_p{1'b0}};
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      v_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      ovf_q      <= ovf_d;
      interval_q <= interval_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      v_q        <= v_d;
    end
  end

  assign meter_if.busy_o     = busy_q;
  assign meter_if.v_o        = v_q;
  assign meter_if.interval_o = interval_q;
  assign meter_if.overflow_o = overflow_q;

`ifdef BSG_CYCLE_INTERVAL_METER_MAX_TRACK_EN
  logic [width_p-1:0] max_q, max_d;

  // Running maximum, updated on the accept handshake; clear has priority.
  always_comb begin
    max_d = max_q;
    if (meter_if.max_clr_i) begin
      max_d = {width_p{1'b0}};
    end else if ((state_q == ST_DONE) && meter_if.yumi_i) begin
      if (overflow_q) begin
        max_d = {width_p{1'b1}};
      end else if (interval_q > max_q) begin
        max_d = interval_q;
      end else begin
        max_d = max_q;
      end
    end else begin
      max_d = max_q;
    end
  end

  // Maximum register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      max_q <= {width_p{1'b0}};
    end else begin
      max_q <= max_d;
    end
  end

  assign meter_if.max_o = max_q;
`endif

endmodule
